// File: rtl/detector_pkg.sv
// Shared types and event layout for the tone-detector sequencer and its event queue.
package detector_pkg;

    localparam int TS_WIDTH     = 24;
    localparam int EVT_WIDTH    = 32;
    localparam int LANE_WIDTH   = 3;
    localparam int EVT_LANE_LSB = 29;
    localparam int EVT_TS_LSB   = 0;

    typedef enum logic [LANE_WIDTH-1:0] {
        SILENCE = 3'd0,
        LANE1   = 3'd1,
        LANE2   = 3'd2,
        LANE3   = 3'd3,
        LANE4   = 3'd4
    } lane_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        HOLD,
        WAIT_SIL
    } seq_state_t;

    // Detector codes 5..7 are not lanes and count as silence.
    function automatic lane_t decode_lane(input logic [LANE_WIDTH-1:0] r);
        return (r >= 3'd1 && r <= 3'd4) ? lane_t'(r) : SILENCE;
    endfunction

    function automatic logic [EVT_WIDTH-1:0] pack_event(input lane_t l,
                                                        input logic [TS_WIDTH-1:0] ts);
        logic [EVT_WIDTH-1:0] ev;
        ev = '0;
        ev[EVT_LANE_LSB +: LANE_WIDTH] = l;
        ev[EVT_TS_LSB +: TS_WIDTH]     = ts;
        return ev;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Show-ahead synchronous FIFO: head word is presented on data_o whenever non-empty.
module event_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      fill_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign fill_o  = cnt_q;
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the slot in the same cycle, so a full queue can still accept.
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/detector_sequencer.sv
// Paces the tone detector, debounces its lane decisions and queues timestamped hit events.
module detector_sequencer
    import detector_pkg::*;
#(
    parameter int DECIM      = 4,
    parameter int HOLDOFF    = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          sample_valid,
    input  logic [2:0]                    overall_result,
    output logic                          advance,
    output logic                          evt_valid,
    output logic [EVT_WIDTH-1:0]          evt_data,
    input  logic                          evt_rd,
    output logic [$clog2(FIFO_DEPTH):0]   fill,
    output logic                          overflow,
    input  logic                          ovf_clr
);

    localparam int CNT_W  = (DECIM > 1)   ? $clog2(DECIM)   : 1;
    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    logic [CNT_W-1:0]    sample_cnt_q;
    logic                advance_q, sen_p1_q, sample_en_q;
    logic [TS_WIDTH-1:0] ts_q;
    seq_state_t          state_q;
    logic [HOLD_W-1:0]   hold_cnt_q;
    logic                overflow_q;

    logic                wrap, push, pop, drop, fifo_full, fifo_empty;
    lane_t               lane;
    logic [EVT_WIDTH-1:0] evt_d;

    assign wrap  = sample_valid && (sample_cnt_q == CNT_W'(DECIM - 1));
    assign lane  = decode_lane(overall_result);
    assign push  = enable && sample_en_q && (state_q == ARMED) && (lane != SILENCE);
    assign evt_d = pack_event(lane, ts_q);
    assign pop   = evt_rd && !fifo_empty;
    assign drop  = push && fifo_full && !pop;

    // Decimator, timestamp and the two-stage delay that lines sample_en up with the detector result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_cnt_q <= '0;
            advance_q    <= 1'b0;
            sen_p1_q     <= 1'b0;
            sample_en_q  <= 1'b0;
            ts_q         <= '0;
        end else begin
            if (!enable) begin
                sample_cnt_q <= '0;
                advance_q    <= 1'b0;
                sen_p1_q     <= 1'b0;
                sample_en_q  <= 1'b0;
            end else begin
                if (sample_valid) sample_cnt_q <= wrap ? '0 : sample_cnt_q + CNT_W'(1);
                advance_q   <= wrap;
                sen_p1_q    <= advance_q;
                sample_en_q <= sen_p1_q;
            end
            if (advance_q) ts_q <= ts_q + TS_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
        end else if (!enable) begin
            state_q    <= IDLE;
        end else begin
            case (state_q)
                IDLE: state_q <= ARMED;
                ARMED: begin
                    if (sample_en_q && lane != SILENCE) begin
                        hold_cnt_q <= HOLD_W'(HOLDOFF - 1);
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    if (sample_en_q) begin
                        if (hold_cnt_q == '0)
                            state_q <= (lane == SILENCE) ? ARMED : WAIT_SIL;
                        else
                            hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
                    end
                end
                WAIT_SIL: begin
                    if (sample_en_q && lane == SILENCE) state_q <= ARMED;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A drop in the same cycle as a clear must leave the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       overflow_q <= 1'b0;
        else if (drop)    overflow_q <= 1'b1;
        else if (ovf_clr) overflow_q <= 1'b0;
    end

    event_fifo #(
        .WIDTH (EVT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (push),
        .data_i  (evt_d),
        .pop_i   (pop),
        .data_o  (evt_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .fill_o  (fill)
    );

    assign advance   = advance_q;
    assign evt_valid = !fifo_empty;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_detector_sequencer.sv
// Randomised scoreboard bench for detector_sequencer against a frame-level reference model.
module tb_detector_sequencer;

    localparam int DECIM   = 4;
    localparam int HOLDOFF = 4;
    localparam int DEPTH   = 8;
    localparam int FW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          sample_valid = 1'b0;
    logic [2:0]    overall_result = 3'd0;
    logic          evt_rd = 1'b0;
    logic          ovf_clr = 1'b0;
    logic          advance, evt_valid, overflow;
    logic [31:0]   evt_data;
    logic [FW-1:0] fill;

    always #5 clk = ~clk;

    detector_sequencer #(
        .DECIM      (DECIM),
        .HOLDOFF    (HOLDOFF),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .sample_valid   (sample_valid),
        .overall_result (overall_result),
        .advance        (advance),
        .evt_valid      (evt_valid),
        .evt_data       (evt_data),
        .evt_rd         (evt_rd),
        .fill           (fill),
        .overflow       (overflow),
        .ovf_clr        (ovf_clr)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts samples, schedules advance/sample instants, applies hit rules.
    bit          model_on = 1'b0;
    int          cyc = 0;
    int          cnt_m = 0;
    int          adv_q[$];
    int          se_q[$];
    logic [23:0] ts_m = '0;
    bit          armed_m = 1'b1;
    int          ignore_m = 0;
    int          fill_m = 0;
    bit          ovf_m = 1'b0;
    logic [31:0] exp_q[$];

    always @(negedge clk) begin
        if (model_on) begin
            bit          pop_m, push_m, drop_m;
            logic [2:0]  lane_m;
            logic [31:0] ev;
            pop_m = 1'b0; push_m = 1'b0; drop_m = 1'b0; ev = '0;
            check("advance", {31'd0, advance}, {31'd0, (adv_q.size() > 0 && adv_q[0] == cyc)});
            check("evt_valid", {31'd0, evt_valid}, {31'd0, (fill_m > 0)});
            check("fill", {{(32-FW){1'b0}}, fill}, fill_m);
            check("overflow", {31'd0, overflow}, {31'd0, ovf_m});
            if (fill_m == 0) check("evt_data_empty", evt_data, 32'd0);
            pop_m = evt_rd && (fill_m > 0);
            if (enable) begin
                if (se_q.size() > 0 && se_q[0] == cyc) begin
                    void'(se_q.pop_front());
                    lane_m = (overall_result >= 3'd1 && overall_result <= 3'd4) ? overall_result : 3'd0;
                    if (ignore_m > 0) ignore_m--;
                    else if (!armed_m) begin
                        if (lane_m == 3'd0) armed_m = 1'b1;
                    end else if (lane_m != 3'd0) begin
                        push_m = 1'b1;
                        ev = {lane_m, 5'd0, ts_m};
                        armed_m = 1'b0;
                        ignore_m = HOLDOFF - 1;
                    end
                end
                if (sample_valid) begin
                    cnt_m++;
                    if (cnt_m == DECIM) begin
                        cnt_m = 0;
                        adv_q.push_back(cyc + 1);
                        se_q.push_back(cyc + 3);
                    end
                end
            end else begin
                cnt_m = 0;
                se_q.delete();
                armed_m = 1'b1;
                ignore_m = 0;
            end
            if (adv_q.size() > 0 && adv_q[0] == cyc) begin
                void'(adv_q.pop_front());
                ts_m = ts_m + 24'd1;
            end
            if (push_m) begin
                if (fill_m < DEPTH || pop_m) begin
                    exp_q.push_back(ev);
                    fill_m++;
                end else drop_m = 1'b1;
            end
            if (drop_m) ovf_m = 1'b1;
            else if (ovf_clr) ovf_m = 1'b0;
            if (pop_m) fill_m--;
            cyc++;
        end
    end

    // Monitor: compares the presented head with the scoreboard and retires it on a read.
    always @(negedge clk) begin
        if (model_on && evt_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL evt_unexpected: got 0x%0h, expected no event at %0t", evt_data, $time);
            end else begin
                check("evt_data", evt_data, exp_q[0]);
                if (evt_rd) void'(exp_q.pop_front());
            end
        end
    end

    int rd_mode = 0;
    bit clr_en = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rd_mode == 1) evt_rd = ($urandom_range(0, 2) == 0);
            if (clr_en) ovf_clr = ($urandom_range(0, 15) == 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [2:0] r);
        overall_result = r;
        for (int i = 0; i < DECIM; i++) begin
            sample_valid = 1'b1;
            step();
            sample_valid = 1'b0;
            repeat ($urandom_range(0, 2)) step();
        end
        repeat (4) step();
    endtask

    function automatic logic [2:0] rand_result();
        return ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
    endfunction

    task automatic enable_drop();
        int k;
        k = $urandom_range(0, DECIM - 1);
        overall_result = rand_result();
        for (int i = 0; i < k; i++) begin
            sample_valid = 1'b1;
            step();
            sample_valid = 1'b0;
            step();
        end
        enable = 1'b0;
        repeat ($urandom_range(1, 3)) step();
        enable = 1'b1;
        step();
    endtask

    task automatic random_frames(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) == 0) enable_drop();
            frame(rand_result());
        end
    endtask

    task automatic fill_up();
        for (int i = 0; i < 12; i++) begin
            frame(3'($urandom_range(1, 4)));
            repeat (HOLDOFF) frame(3'd0);
        end
    endtask

    initial begin
        repeat (3) step();
        check("rst_advance", {31'd0, advance}, 32'd0);
        check("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
        check("rst_evt_data", evt_data, 32'd0);
        check("rst_fill", {{(32-FW){1'b0}}, fill}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);

        reset = 1'b1;
        model_on = 1'b1;
        step();
        enable = 1'b1;
        step();

        rd_mode = 1;
        frame(3'd2);
        repeat (8) frame(3'd2);
        frame(3'd1);
        repeat (4) frame(3'd0);
        frame(3'd3);
        repeat (6) frame(3'd1);
        repeat (4) frame(3'd0);

        random_frames(60);

        rd_mode = 0;
        step();
        evt_rd = 1'b0;
        fill_up();
        check("full_fill", {{(32-FW){1'b0}}, fill}, DEPTH);
        check("full_overflow", {31'd0, overflow}, 32'd1);

        // Hit lands while full and a read is issued in the same cycle.
        overall_result = 3'd4;
        for (int i = 0; i < DECIM; i++) begin
            sample_valid = 1'b1;
            step();
        end
        sample_valid = 1'b0;
        step();
        step();
        evt_rd = 1'b1;
        step();
        evt_rd = 1'b0;
        check("pushpop_fill", {{(32-FW){1'b0}}, fill}, DEPTH);
        repeat (HOLDOFF) frame(3'd0);

        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        rd_mode = 1;
        clr_en = 1'b1;
        random_frames(40);

        rd_mode = 0;
        clr_en = 1'b0;
        step();
        evt_rd = 1'b0;
        ovf_clr = 1'b0;
        fill_up();
        check("pre_reset_fill", {{(32-FW){1'b0}}, fill}, DEPTH);
        check("pre_reset_overflow", {31'd0, overflow}, 32'd1);

        @(posedge clk);
        #2;
        model_on = 1'b0;
        reset = 1'b0;
        #1;
        check("async_evt_valid", {31'd0, evt_valid}, 32'd0);
        check("async_fill", {{(32-FW){1'b0}}, fill}, 32'd0);
        check("async_overflow", {31'd0, overflow}, 32'd0);
        check("async_evt_data", evt_data, 32'd0);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
